// File: rtl/controle_microondas.sv
// Microwave oven control FSM: keypad entry, cook/pause/done sequencing, countdown strobes.
// Optional done alarm (beep port, tick counter) enabled by `define MICROONDAS_ALARME_EN.
module controle_microondas #(
   parameter int BEEP_CYCLES = 8
) (
   input  logic       CLK,
   input  logic       clear,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       start,
   input  logic       stop_clear,
   input  logic       door_closed,
   input  logic       tick_1hz,
   input  logic       timer_done,
   output logic [3:0] cnt_data,
   output logic       cnt_load,
   output logic       cnt_enable,
   output logic       cnt_clear,
   output logic       mag_on,
`ifdef MICROONDAS_ALARME_EN
   output logic       beep,
`endif
   output logic [2:0] state_o
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ENTRY   = 3'd1;
   localparam logic [2:0] COOKING = 3'd2;
   localparam logic [2:0] PAUSED  = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;

   if (BEEP_CYCLES < 1) begin : g_bad_param
      $error("BEEP_CYCLES must be at least 1");
   end

   logic [2:0] state_q, state_d;
   logic [1:0] count_q, count_d;
   logic [3:0] cnt_data_q, cnt_data_d;
   logic       cnt_load_q, cnt_load_d;
   logic       cnt_enable_q, cnt_enable_d;
   logic       cnt_clear_q, cnt_clear_d;
   logic       key_ok;

`ifdef MICROONDAS_ALARME_EN
   localparam int BW = $clog2(BEEP_CYCLES + 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);
   logic [BW-1:0] beep_cnt_q, beep_cnt_d;
`endif

   assign key_ok = key_valid && (key_digit <= 4'd9) && (count_q != 2'd3);

   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      cnt_data_d   = cnt_data_q;
      cnt_load_d   = 1'b0;
      cnt_enable_d = 1'b0;
      cnt_clear_d  = 1'b0;
`ifdef MICROONDAS_ALARME_EN
      beep_cnt_d   = beep_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (!stop_clear && key_ok) begin
               cnt_data_d = key_digit;
               cnt_load_d = 1'b1;
               count_d    = count_q + 2'd1;
               state_d    = ENTRY;
            end
         end
         ENTRY: begin
            if (stop_clear) begin
               cnt_clear_d = 1'b1;
               count_d     = 2'd0;
               state_d     = IDLE;
            end else if (start && door_closed && !timer_done) begin
               state_d = COOKING;
            end else if (key_ok) begin
               cnt_data_d = key_digit;
               cnt_load_d = 1'b1;
               count_d    = count_q + 2'd1;
            end
         end
         COOKING: begin
            // An open door wins over the tick, so that second is not counted.
            if (!door_closed || stop_clear) begin
               state_d = PAUSED;
            end else if (timer_done) begin
               state_d = DONE;
`ifdef MICROONDAS_ALARME_EN
               beep_cnt_d = '0;
`endif
            end else if (tick_1hz) begin
               cnt_enable_d = 1'b1;
            end
         end
         PAUSED: begin
            if (stop_clear) begin
               cnt_clear_d = 1'b1;
               count_d     = 2'd0;
               state_d     = IDLE;
            end else if (start && door_closed) begin
               state_d = COOKING;
            end
         end
         DONE: begin
`ifdef MICROONDAS_ALARME_EN
            if (stop_clear || (tick_1hz && beep_cnt_q == BEEP_LAST)) begin
               cnt_clear_d = 1'b1;
               count_d     = 2'd0;
               state_d     = IDLE;
            end else if (tick_1hz) begin
               beep_cnt_d = beep_cnt_q + BW'(1);
            end
`else
            cnt_clear_d = 1'b1;
            count_d     = 2'd0;
            state_d     = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (clear) begin
         state_q      <= IDLE;
         count_q      <= 2'd0;
         cnt_data_q   <= 4'd0;
         cnt_load_q   <= 1'b0;
         cnt_enable_q <= 1'b0;
         cnt_clear_q  <= 1'b1;
`ifdef MICROONDAS_ALARME_EN
         beep_cnt_q   <= '0;
`endif
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         cnt_data_q   <= cnt_data_d;
         cnt_load_q   <= cnt_load_d;
         cnt_enable_q <= cnt_enable_d;
         cnt_clear_q  <= cnt_clear_d;
`ifdef MICROONDAS_ALARME_EN
         beep_cnt_q   <= beep_cnt_d;
`endif
      end
   end

   assign cnt_data   = cnt_data_q;
   assign cnt_load   = cnt_load_q;
   assign cnt_enable = cnt_enable_q;
   assign cnt_clear  = cnt_clear_q;
   assign state_o    = state_q;
   assign mag_on     = (state_q == COOKING) && door_closed;
`ifdef MICROONDAS_ALARME_EN
   assign beep       = (state_q == DONE);
`endif

endmodule

// File: doc/controle_microondas.md
CONTROLE_MICROONDAS -- requirements
Module: controle_microondas

Interface
REQ-001 SHALL have parameter BEEP_CYCLES, default 8, meaning the number of tick_1hz pulses the done alarm is held.
REQ-002 SHALL have port CLK, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port clear, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port key_valid, input, 1 bit, one-cycle strobe marking a keypad digit.
REQ-005 SHALL have port key_digit, input, 4 bits, BCD digit qualified by key_valid.
REQ-006 SHALL have port start, input, 1 bit, one-cycle start/resume strobe.
REQ-007 SHALL have port stop_clear, input, 1 bit, one-cycle stop/cancel strobe.
REQ-008 SHALL have port door_closed, input, 1 bit, level; 1 = door shut.
REQ-009 SHALL have port tick_1hz, input, 1 bit, one-cycle strobe once per second.
REQ-010 SHALL have port timer_done, input, 1 bit, level from the countdown datapath; 1 = all digits zero.
REQ-011 SHALL have port cnt_data, output, 4 bits, digit presented to the countdown datapath.
REQ-012 SHALL have port cnt_load, output, 1 bit, one-cycle strobe shifting cnt_data into the datapath.
REQ-013 SHALL have port cnt_enable, output, 1 bit, one-cycle decrement strobe.
REQ-014 SHALL have port cnt_clear, output, 1 bit, one-cycle strobe zeroing the datapath.
REQ-015 SHALL have port mag_on, output, 1 bit, magnetron/lamp drive.
REQ-016 SHALL have port state_o, output, 3 bits, current state encoding.
REQ-017 SHALL have port beep, output, 1 bit, done alarm; present only with ALARME_EN.

Function
REQ-018 SHALL implement states IDLE=0, ENTRY=1, COOKING=2, PAUSED=3, DONE=4; other encodings return to IDLE next cycle.
REQ-019 SHALL, in IDLE or ENTRY, on key_valid with key_digit <= 9 and digit count < 3, register cnt_data=key_digit and pulse cnt_load the next cycle, increment the count, and go/stay ENTRY.
REQ-020 SHALL ignore key_valid with key_digit > 9, with count = 3, or in COOKING/PAUSED/DONE.
REQ-021 SHALL go ENTRY->COOKING on start when door_closed=1 and timer_done=0; start is ignored otherwise.
REQ-022 SHALL, in COOKING, assert cnt_enable for exactly the cycle after each tick_1hz while timer_done=0.
REQ-023 SHALL drive mag_on=1 only in COOKING with door_closed=1, combinationally gated by door_closed.
REQ-024 SHALL go COOKING->PAUSED when door_closed=0 or on stop_clear; PAUSED->COOKING on start with door_closed=1.
REQ-025 SHALL go COOKING->DONE when timer_done=1; no cnt_enable is issued in that cycle.
REQ-026 SHALL, on stop_clear in ENTRY, PAUSED or DONE, pulse cnt_clear, zero the digit count and go IDLE.
REQ-027 SHALL give stop_clear priority over start and key_valid when asserted in the same cycle.
REQ-028 SHALL give door_closed=0 priority over tick_1hz in COOKING: the cycle's pulse is dropped.
REQ-029 SHALL never assert cnt_load, cnt_enable and cnt_clear in the same cycle.
REQ-030 SHALL, in DONE without ALARME_EN, return to IDLE on the next cycle with cnt_clear pulsed.

Reset
REQ-031 SHALL, on clear=1 at a clock edge, force IDLE, digit count 0, cnt_data=0, cnt_load=0, cnt_enable=0, mag_on=0, beep=0, and pulse cnt_clear=1 in the following cycle.
REQ-032 SHALL have clear override all inputs, including mid-cook, with mag_on low from the cycle after the edge.

Configuration
REQ-033 SHALL, with macro MICROONDAS_ALARME_EN defined, hold DONE with beep=1 for BEEP_CYCLES tick_1hz pulses, then pulse cnt_clear and go IDLE; stop_clear ends it early.
REQ-034 SHALL, without MICROONDAS_ALARME_EN, omit the beep port and tick counter, DONE lasting one cycle per REQ-030.

Verification
REQ-035 SHALL cover: clear, keys 1,3,0 -> three cnt_load pulses with cnt_data 1,3,0; fourth key 5 -> no cnt_load.
REQ-036 SHALL cover: entry then start with door_closed=1 -> COOKING, mag_on=1, one cnt_enable per tick_1hz over 10 ticks.
REQ-037 SHALL cover: door_closed=0 mid-cook coinciding with tick -> PAUSED, mag_on=0 same cycle, no cnt_enable; start with door shut -> COOKING.
REQ-038 SHALL cover: timer_done=1 in COOKING -> DONE, mag_on=0; with ALARME_EN beep=1 for 8 ticks then cnt_clear and IDLE.
REQ-039 SHALL cover: stop_clear and start same cycle in PAUSED -> cnt_clear pulse, IDLE.
REQ-040 SHALL cover: clear asserted mid-cook -> IDLE, mag_on=0, cnt_clear pulse next cycle.
